// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word geometry
// and the address legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES  = 4;
  localparam int ADDR_LSB    = 2;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

  // Illegal when not word aligned or when the word index falls past the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    return (addr[ADDR_LSB-1:0] != '0) || ((addr >> (ADDR_LSB + aw)) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array: per-lane write enables, registered read data.
// One cycle from enable to rdata; no flow control, rdata holds until the next enable.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory slave: one outstanding request, rsp_valid LATENCY cycles after
// acceptance; req_ready stays low until the response handshake. DMEM_STATS_EN adds counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
`ifdef DMEM_STATS_EN
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [15:0] err_count,
`endif
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             lat_write;
  logic             lat_err;
  logic [AW-1:0]    lat_idx;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_wstrb;
  logic             rsp_load;

  logic             accept;
  logic             req_err;
  logic             from_idle;
  logic             go_resp;
  logic             cur_write;
  logic             cur_err;
  logic [3:0]       cur_wstrb;
  logic             arr_en;
  logic [3:0]       arr_we;
  logic [AW-1:0]    arr_idx;
  logic [31:0]      arr_wdata;
  logic [31:0]      arr_rdata;

  assign accept    = req_valid && req_ready;
  assign req_err   = addr_err(req_addr, AW);
  assign from_idle = accept && (LATENCY == 1);
  // Loaded with LATENCY-1 on accept; the decrement that reaches zero is the RESP entry edge.
  assign go_resp   = from_idle || ((state == WAIT) && (cnt == CNT_W'(1)));

  // With LATENCY=1 the array is accessed on the acceptance edge, straight from the request.
  assign cur_write = from_idle ? req_write : lat_write;
  assign cur_err   = from_idle ? req_err   : lat_err;
  assign cur_wstrb = from_idle ? req_wstrb : lat_wstrb;
  assign arr_idx   = from_idle ? req_addr[ADDR_LSB +: AW] : lat_idx;
  assign arr_wdata = from_idle ? req_wdata : lat_wdata;

  // Reset on the commit edge must also suppress the write.
  assign arr_en    = go_resp && !reset;
  assign arr_we    = (cur_write && !cur_err) ? cur_wstrb : 4'b0000;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_load  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_idx   <= req_addr[ADDR_LSB +: AW];
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state     <= RESP;
              cnt       <= '0;
              rsp_valid <= 1'b1;
              rsp_err   <= req_err;
              rsp_load  <= !req_write && !req_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (go_resp) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= lat_err;
            rsp_load  <= !lat_write && !lat_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_load  <= 1'b0;
        end
      endcase
    end
  end

  // Array rdata only changes on an enable, so it is stable for the whole of RESP.
  assign rsp_rdata = rsp_load ? arr_rdata : 32'h0;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (lat_err)        err_count <= err_count + 1'b1;
      else if (lat_write) wr_count  <= wr_count + 1'b1;
      else                rd_count  <= rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus random traffic against a word-array model,
// with LATENCY=1 and LATENCY=15 side instances for latency measurement.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int AWB   = 6;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        aux_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_ready;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        a1_ready, a1_valid, a1_err;
  logic [31:0] a1_rdata;
  logic        a15_ready, a15_valid, a15_err;
  logic [31:0] a15_rdata;
`ifdef DMEM_STATS_EN
  logic [31:0] rd_count, wr_count, a1_rd, a1_wr, a15_rd, a15_wr;
  logic [15:0] err_count, a1_ec, a15_ec;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef DMEM_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count),
`endif
    .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(aux_valid), .req_ready(a1_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(a1_valid), .rsp_ready(rsp_ready), .rsp_rdata(a1_rdata),
`ifdef DMEM_STATS_EN
    .rd_count(a1_rd), .wr_count(a1_wr), .err_count(a1_ec),
`endif
    .rsp_err(a1_err)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(15)) dut_l15 (
    .clk(clk), .reset(reset), .req_valid(aux_valid), .req_ready(a15_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(a15_valid), .rsp_ready(rsp_ready), .rsp_rdata(a15_rdata),
`ifdef DMEM_STATS_EN
    .rd_count(a15_rd), .wr_count(a15_wr), .err_count(a15_ec),
`endif
    .rsp_err(a15_err)
  );

  int          total  = 0;
  int          passed = 0;
  logic [31:0] model_mem [DEPTH];
  int          exp_rd = 0;
  int          exp_wr = 0;
  int          exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_err = 0;
  endtask

  // One transaction on the main instance; hold = cycles rsp_ready stays low in RESP.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int hold, output logic [31:0] got);
    logic        e;
    logic [31:0] exp_rdata;
    int          cyc;
    int          lat;
    e = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    exp_rdata = (!w && !e) ? model_mem[a[2 +: AWB]] : 32'h0;
    got = 32'h0;

    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    rsp_ready = 1'($urandom_range(0, 1));
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("issue_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    // Scramble the request after acceptance: it must not affect the in-flight access.
    req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      chk("wait_ready", 32'(req_ready), 32'd0);
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    got = rsp_rdata;
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_ready_low", 32'(req_ready), 32'd0);
      chk("rdata", rsp_rdata, exp_rdata);
      chk("err", 32'(rsp_err), 32'(e));
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);

    if (e) exp_err++;
    else if (w) begin
      exp_wr++;
      for (int i = 0; i < 4; i++)
        if (s[i]) model_mem[a[2 +: AWB]][8*i +: 8] = d[8*i +: 8];
    end else exp_rd++;
  endtask

  // One request into both side instances at once; reports per-instance latency and response.
  task automatic aux_xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int l1, output int l15,
                          output logic [31:0] r1, output logic [31:0] r15,
                          output logic e1, output logic e15);
    @(negedge clk);
    aux_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = 4'hF;
    rsp_ready = 1'b1;
    chk("aux_issue_ready", 32'(a1_ready & a15_ready), 32'd1);
    @(negedge clk);
    aux_valid = 1'b0;
    l1 = 0; l15 = 0; r1 = '0; r15 = '0; e1 = 1'b0; e15 = 1'b0;
    for (int k = 1; k <= 40 && (l1 == 0 || l15 == 0); k++) begin
      if (l1 == 0 && a1_valid)   begin l1 = k;  r1 = a1_rdata;   e1 = a1_err;   end
      if (l15 == 0 && a15_valid) begin l15 = k; r15 = a15_rdata; e15 = a15_err; end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    int          l1, l15;
    logic [31:0] r1, r15;
    logic        e1, e15;

    reset = 1'b1; req_valid = 1'b0; aux_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
    do_reset(3);
`ifdef DMEM_STATS_EN
    chk("stats_rst_rd", rd_count, 32'd0);
    chk("stats_rst_err", 32'(err_count), 32'd0);
`endif

    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i) << 2, $urandom, 4'hF, 0, got);

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
    chk("store_rdata_zero", got, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, 0, got);
    chk("read_back", got, 32'hDEADBEEF);

    xact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, got);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, got);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    chk("lane_merge", got, 32'h11BB33DD);
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, got);
    xact(1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    chk("wstrb_zero_noop", got, 32'h11BB33DD);

    xact(1'b0, 32'h13, 32'h0, 4'h0, 0, got);
    xact(1'b1, 32'(4 * DEPTH), 32'h12345678, 4'hF, 0, got);
    xact(1'b0, 32'h0, 32'h0, 4'h0, 0, got);
    xact(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 0, got);

    xact(1'b0, 32'h10, 32'h0, 4'h0, 5, got);
    chk("backpressure_rdata", got, 32'hDEADBEEF);

    // Reset lands on the edge that would have committed the write.
    xact(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, got);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_wstrb = 4'hF;
    chk("midop_issue_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    check_idle_outputs("midop");
    repeat (3) begin
      @(negedge clk);
      chk("midop_no_rsp", 32'(rsp_valid), 32'd0);
    end
    xact(1'b0, 32'h40, 32'h0, 4'h0, 0, got);
    chk("midop_prior_value", got, 32'hCAFEF00D);

    aux_xact(1'b1, 32'h8, 32'h0BADF00D, l1, l15, r1, r15, e1, e15);
    chk("lat1_write", 32'(l1), 32'd1);
    chk("lat15_write", 32'(l15), 32'd15);
    aux_xact(1'b0, 32'h8, 32'h0, l1, l15, r1, r15, e1, e15);
    chk("lat1_read", 32'(l1), 32'd1);
    chk("lat15_read", 32'(l15), 32'd15);
    chk("lat1_rdata", r1, 32'h0BADF00D);
    chk("lat15_rdata", r15, 32'h0BADF00D);
    aux_xact(1'b0, 32'h43, 32'h0, l1, l15, r1, r15, e1, e15);
    chk("lat1_err", 32'(e1), 32'd1);
    chk("lat15_err", 32'(e15), 32'd1);
    chk("lat1_err_rdata", r1, 32'h0);

    for (int n = 0; n < 200; n++) begin
      int          r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      else if (r == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0100;
      xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), got);
    end

`ifdef DMEM_STATS_EN
    chk("stats_rd", rd_count, 32'(exp_rd));
    chk("stats_wr", wr_count, 32'(exp_wr));
    chk("stats_err", 32'(err_count), 32'(exp_err));
    do_reset(1);
    chk("stats_clr_wr", wr_count, 32'd0);
    xact(1'b0, 32'h0, 32'h0, 4'h0, 0, got);
    xact(1'b0, 32'h4, 32'h0, 4'h0, 0, got);
    xact(1'b0, 32'h8, 32'h0, 4'h0, 0, got);
    xact(1'b1, 32'hC, 32'h1, 4'hF, 0, got);
    xact(1'b1, 32'h14, 32'h2, 4'h3, 1, got);
    xact(1'b0, 32'h2, 32'h0, 4'h0, 0, got);
    chk("stats_3_rd", rd_count, 32'd3);
    chk("stats_2_wr", wr_count, 32'd2);
    chk("stats_1_err", 32'(err_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
